// File: rtl/mem_fill_arbiter.sv
// Sole owner of the unified memory: arbitrates D-cache stores, D-cache fills and I-cache fills,
// sequences pipelined 8-word block reads, steers returned words into the caches and drives stalls.
module mem_fill_arbiter #(
    parameter int  MEM_LATENCY     = 4,
    parameter int  WORDS_PER_BLOCK = 8,
    localparam int WW              = $clog2(WORDS_PER_BLOCK)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          icache_miss,
    input  logic [15:0]   icache_miss_addr,
    input  logic          dcache_miss,
    input  logic [15:0]   dcache_miss_addr,
    input  logic          dcache_wr,
    input  logic [15:0]   dcache_wr_addr,
    input  logic [15:0]   dcache_wr_data,
    input  logic          mem_data_valid,
    input  logic [15:0]   mem_data_out,
    output logic          mem_enable,
    output logic          mem_wr,
    output logic [15:0]   mem_addr,
    output logic [15:0]   mem_data_in,
    output logic [15:0]   fill_data,
    output logic [WW-1:0] fill_word,
    output logic          icache_fill_we,
    output logic          dcache_fill_we,
    output logic          icache_tag_we,
    output logic          dcache_tag_we,
    output logic          dcache_wr_ack,
    output logic          icache_stall,
    output logic          dcache_stall
);

    localparam logic [15:0]   BLOCK_MASK = ~16'(2 * WORDS_PER_BLOCK - 1);
    localparam logic [WW-1:0] LAST_WORD  = WW'(WORDS_PER_BLOCK - 1);

    generate
        if (MEM_LATENCY < 1) begin : g_bad_latency
            $error("MEM_LATENCY must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, WRITE, FILL_I, FILL_D} state_t;

    // Requester protocol: a requester raises its request (miss or store) with a stable address
    // and holds it until the matching completion pulse (tag_we for misses, dcache_wr_ack for
    // stores); the completion pulse is the only acknowledgement and lasts exactly one cycle.
    state_t        state;
    state_t        state_nxt;
    logic [WW-1:0] issue_cnt;
    logic [WW-1:0] recv_cnt;
    logic          issue_done;
    logic          recv_done;
    logic [15:0]   base;
    logic          fill_hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            issue_cnt  <= '0;
            recv_cnt   <= '0;
            issue_done <= 1'b0;
            recv_done  <= 1'b0;
            base       <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                issue_cnt  <= '0;
                recv_cnt   <= '0;
                issue_done <= 1'b0;
                recv_done  <= 1'b0;
                if (state_nxt == FILL_D) begin
                    base <= dcache_miss_addr & BLOCK_MASK;
                end else if (state_nxt == FILL_I) begin
                    base <= icache_miss_addr & BLOCK_MASK;
                end
            end else if (state == FILL_I || state == FILL_D) begin
                if (mem_enable) begin
                    issue_cnt <= issue_cnt + 1'b1;
                    if (issue_cnt == LAST_WORD) issue_done <= 1'b1;
                end
                if (fill_hit) begin
                    recv_cnt <= recv_cnt + 1'b1;
                    if (recv_cnt == LAST_WORD) recv_done <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        mem_enable     = 1'b0;
        mem_wr         = 1'b0;
        mem_addr       = '0;
        mem_data_in    = '0;
        fill_data      = '0;
        fill_word      = '0;
        icache_fill_we = 1'b0;
        dcache_fill_we = 1'b0;
        icache_tag_we  = 1'b0;
        dcache_tag_we  = 1'b0;
        dcache_wr_ack  = 1'b0;
        fill_hit       = 1'b0;
        case (state)
            IDLE: begin
                if (dcache_wr)        state_nxt = WRITE;
                else if (dcache_miss) state_nxt = FILL_D;
                else if (icache_miss) state_nxt = FILL_I;
            end
            WRITE: begin
                mem_enable    = 1'b1;
                mem_wr        = 1'b1;
                mem_addr      = dcache_wr_addr;
                mem_data_in   = dcache_wr_data;
                dcache_wr_ack = 1'b1;
                state_nxt     = IDLE;
            end
            FILL_I, FILL_D: begin
                // Reads are issued back to back while earlier words are still returning.
                if (!issue_done) begin
                    mem_enable = 1'b1;
                    mem_addr   = base + {{(15 - WW){1'b0}}, issue_cnt, 1'b0};
                end
                if (mem_data_valid && !recv_done) begin
                    fill_hit       = 1'b1;
                    fill_data      = mem_data_out;
                    fill_word      = recv_cnt;
                    icache_fill_we = (state == FILL_I);
                    dcache_fill_we = (state == FILL_D);
                    if (recv_cnt == LAST_WORD) begin
                        icache_tag_we = (state == FILL_I);
                        dcache_tag_we = (state == FILL_D);
                        state_nxt     = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign icache_stall = icache_miss | (state == FILL_I);
    assign dcache_stall = dcache_miss | (state == FILL_D) | (dcache_wr & ~dcache_wr_ack);

endmodule
